fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of the team's FIFO between two producers. Each producer presents a word with a level request. The arbiter grants one producer at a time for a bounded burst of words, then rotates. It drives the FIFO WRITE/DATA_IN inputs directly and stalls on the FIFO full flag (F_FULL_N), so no word is lost or duplicated.

---
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers.
// Grants bounded bursts, stalls on FIFO full, and passes data through with no latency.
module fifo_wr_arbiter #(
  parameter int mem_width = 8,
  parameter int burst_len = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 REQ0,
  input  logic [mem_width-1:0] DATA0,
  input  logic                 REQ1,
  input  logic [mem_width-1:0] DATA1,
  input  logic                 F_FULL_N,
  output logic                 ACK0,
  output logic                 ACK1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 FIFO_WRITE,
  output logic [mem_width-1:0] FIFO_DATA
);

  localparam int CW = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(burst_len - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign ACK0       = (state_q == GRANT0) && REQ0 && F_FULL_N;
  assign ACK1       = (state_q == GRANT1) && REQ1 && F_FULL_N;
  assign FIFO_WRITE = ACK0 || ACK1;
  assign FIFO_DATA  = ACK0 ? DATA0 : (ACK1 ? DATA1 : '0);
  assign GNT0       = (state_q == GRANT0);
  assign GNT1       = (state_q == GRANT1);

  // Full only stalls; rotation happens on withdrawal or when the burst's last word is taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (REQ0 && REQ1)
          state_d = last_q ? GRANT0 : GRANT1;
        else if (REQ0)
          state_d = GRANT0;
        else if (REQ1)
          state_d = GRANT1;
      end
      GRANT0: begin
        if (!REQ0) begin
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = REQ1 ? GRANT1 : IDLE;
        end else if (ACK0) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = REQ1 ? GRANT1 : GRANT0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GRANT1: begin
        if (!REQ1) begin
          cnt_d   = '0;
          last_d  = 1'b1;
          state_d = REQ0 ? GRANT0 : IDLE;
        end else if (ACK1) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            last_d  = 1'b1;
            state_d = REQ0 ? GRANT0 : GRANT1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a burst_len=4 and a burst_len=1 instance share
// the same producer inputs and are compared every cycle against an owner/word-count model.
module tb_fifo_wr_arbiter;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       REQ0, REQ1, F_FULL_N;
  logic [7:0] DATA0, DATA1;

  logic       ack0[2], ack1[2], gnt0[2], gnt1[2], fw[2];
  logic [7:0] fd[2];

  int nChecks = 0;
  int nFail   = 0;

  int mOwner[2];
  int mUsed[2];
  int mLast[2];
  int burstOf[2] = '{4, 1};

  logic [7:0] wr[$];

  always #5 CLOCK = ~CLOCK;

  fifo_wr_arbiter #(.mem_width(8), .burst_len(4)) dutA (
    .CLOCK(CLOCK), .RESET(RESET), .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
    .F_FULL_N(F_FULL_N), .ACK0(ack0[0]), .ACK1(ack1[0]), .GNT0(gnt0[0]), .GNT1(gnt1[0]),
    .FIFO_WRITE(fw[0]), .FIFO_DATA(fd[0])
  );

  fifo_wr_arbiter #(.mem_width(8), .burst_len(1)) dutB (
    .CLOCK(CLOCK), .RESET(RESET), .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
    .F_FULL_N(F_FULL_N), .ACK0(ack0[1]), .ACK1(ack1[1]), .GNT0(gnt0[1]), .GNT1(gnt1[1]),
    .FIFO_WRITE(fw[1]), .FIFO_DATA(fd[1])
  );

  function automatic logic reqOf(int k);
    return (k == 0) ? REQ0 : REQ1;
  endfunction

  // The model tracks who owns the port and how many words that owner has written so far.
  function automatic logic expAck(int u, int k);
    return (mOwner[u] == k) && (reqOf(k) === 1'b1) && (F_FULL_N === 1'b1);
  endfunction

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      mOwner[u] = -1;
      mUsed[u]  = 0;
      mLast[u]  = 1;
    end
  endtask

  task automatic modelStep();
    for (int u = 0; u < 2; u++) begin
      int k, o;
      if (mOwner[u] < 0) begin
        if (REQ0 && REQ1) mOwner[u] = 1 - mLast[u];
        else if (REQ0)    mOwner[u] = 0;
        else if (REQ1)    mOwner[u] = 1;
      end else begin
        k = mOwner[u];
        o = 1 - k;
        if (!reqOf(k)) begin
          mUsed[u]  = 0;
          mLast[u]  = k;
          mOwner[u] = reqOf(o) ? o : -1;
        end else if (F_FULL_N) begin
          mUsed[u]++;
          if (mUsed[u] == burstOf[u]) begin
            mUsed[u]  = 0;
            mLast[u]  = k;
            mOwner[u] = reqOf(o) ? o : k;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rq0, input logic [7:0] dt0, input logic rq1,
                               input logic [7:0] dt1, input logic fn);
    REQ0 = rq0; DATA0 = dt0; REQ1 = rq1; DATA1 = dt1; F_FULL_N = fn;
    #2;
  endtask

  task automatic setReset(input logic v);
    RESET = v;
    if (v) modelReset();
    #2;
  endtask

  task automatic checkOutput(input string tag);
    for (int u = 0; u < 2; u++) begin
      logic e0, e1;
      logic [7:0] ed;
      e0 = expAck(u, 0);
      e1 = expAck(u, 1);
      ed = e0 ? DATA0 : (e1 ? DATA1 : 8'h00);
      chk($sformatf("%s/u%0d/GNT0", tag, u), 32'(gnt0[u]), 32'(mOwner[u] == 0));
      chk($sformatf("%s/u%0d/GNT1", tag, u), 32'(gnt1[u]), 32'(mOwner[u] == 1));
      chk($sformatf("%s/u%0d/ACK0", tag, u), 32'(ack0[u]), 32'(e0));
      chk($sformatf("%s/u%0d/ACK1", tag, u), 32'(ack1[u]), 32'(e1));
      chk($sformatf("%s/u%0d/WRITE", tag, u), 32'(fw[u]), 32'(e0 | e1));
      chk($sformatf("%s/u%0d/DATA", tag, u), 32'(fd[u]), 32'(ed));
    end
  endtask

  task automatic clockStep();
    @(posedge CLOCK);
    if (RESET) modelReset();
    else modelStep();
    #1;
  endtask

  initial begin
    logic [7:0] d0, d1;
    logic a0, a1, p0, p1;
    int gnt1Seen;

    REQ0 = 0; REQ1 = 0; DATA0 = 0; DATA1 = 0; F_FULL_N = 1;
    RESET = 1;
    modelReset();
    #3;
    checkOutput("reset");
    clockStep();
    clockStep();
    setReset(0);
    clockStep();

    $display("[TB] producer 0 alone, new word per ACK");
    d0 = 8'h11;
    gnt1Seen = 0;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1, d0, 0, 8'h00, 1);
      checkOutput("solo0");
      if (fw[0]) wr.push_back(fd[0]);
      if (gnt1[0]) gnt1Seen++;
      a0 = expAck(0, 0);
      clockStep();
      if (a0) d0++;
    end
    chk("solo0/count", 32'(wr.size()), 32'd7);
    for (int i = 0; i < 4; i++)
      if (i < wr.size()) chk($sformatf("solo0/word%0d", i), 32'(wr[i]), 32'(8'h11 + i));
    chk("solo0/noGnt1", 32'(gnt1Seen), 32'd0);

    $display("[TB] both producers requesting continuously");
    d0 = 8'hA0; d1 = 8'hB0;
    for (int n = 0; n < 14; n++) begin
      applyStimulus(1, d0, 1, d1, 1);
      checkOutput("both");
      a0 = expAck(0, 0); a1 = expAck(0, 1);
      clockStep();
      if (a0) d0++;
      if (a1) d1++;
    end

    $display("[TB] stall on full inside a producer 1 burst");
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOutput("idle1");
    clockStep();
    clockStep();
    d1 = 8'hC0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1, 8'h55, 1, d1, !(n >= 3 && n < 6));
      checkOutput("full");
      a1 = expAck(0, 1);
      clockStep();
      if (a1) d1++;
    end

    $display("[TB] withdrawal by producer 0 after one word");
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    checkOutput("idle2");
    clockStep();
    clockStep();
    applyStimulus(1, 8'h21, 0, 8'h00, 1);
    checkOutput("wdGrant");
    clockStep();
    applyStimulus(1, 8'h21, 0, 8'h00, 1);
    checkOutput("wdAck");
    clockStep();
    d1 = 8'hD0;
    for (int n = 0; n < 7; n++) begin
      applyStimulus(0, 8'h22, 1, d1, 1);
      checkOutput("wdP1");
      a1 = expAck(0, 1);
      clockStep();
      if (a1) d1++;
    end

    $display("[TB] reset in the middle of a burst");
    applyStimulus(0, 8'h00, 0, 8'h00, 1);
    clockStep();
    clockStep();
    d0 = 8'h31;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, d0, 0, 8'h00, 1);
      checkOutput("preRst");
      a0 = expAck(0, 0);
      clockStep();
      if (a0) d0++;
    end
    applyStimulus(1, d0, 0, 8'h00, 1);
    checkOutput("preRstAck");
    setReset(1);
    checkOutput("inRst");
    chk("inRst/WRITE", 32'(fw[0]), 32'd0);
    clockStep();
    applyStimulus(1, d0, 1, 8'h41, 1);
    checkOutput("inRstHeld");
    setReset(0);
    checkOutput("rstRel");
    clockStep();
    applyStimulus(1, d0, 1, 8'h41, 1);
    checkOutput("postRst");
    chk("postRst/firstGnt0", 32'(gnt0[0]), 32'd1);
    clockStep();

    $display("[TB] randomized producers and full flag");
    p0 = 0; p1 = 0; d0 = 0; d1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin p0 = 1; d0 = 8'($urandom); end
      else if (p0 && $urandom_range(0, 19) == 0) p0 = 0;
      if (!p1 && $urandom_range(0, 9) < 6) begin p1 = 1; d1 = 8'($urandom); end
      else if (p1 && $urandom_range(0, 19) == 0) p1 = 0;
      applyStimulus(p0, d0, p1, d1, ($urandom_range(0, 3) != 0));
      checkOutput("rand");
      a0 = expAck(0, 0); a1 = expAck(0, 1);
      clockStep();
      if (a0) p0 = 0;
      if (a1) p1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
